// File: rtl/lock_chk_pkg.sv
// Shared types and helpers for the logic-lock equivalence checker:
// FSM states, maximal-length LFSR tap table and a popcount helper.
package lock_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    REPORT,
    DONE
  } state_e;

  localparam int TAP_MAX = 64;
  localparam int POP_MAX = 256;

  // Counter width helper: never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [TAP_MAX-1:0] tap_bits(input int a, input int b,
                                                  input int c, input int d);
    logic [TAP_MAX-1:0] m;
    m = '0;
    if (a > 0) m = m | (TAP_MAX'(1) << (a - 1));
    if (b > 0) m = m | (TAP_MAX'(1) << (b - 1));
    if (c > 0) m = m | (TAP_MAX'(1) << (c - 1));
    if (d > 0) m = m | (TAP_MAX'(1) << (d - 1));
    return m;
  endfunction

  // Tap positions (1-based) of primitive polynomials, register shifts toward the MSB.
  function automatic logic [TAP_MAX-1:0] lfsr_taps(input int w);
    case (w)
      2:  return tap_bits(2, 1, 0, 0);
      3:  return tap_bits(3, 2, 0, 0);
      4:  return tap_bits(4, 3, 0, 0);
      5:  return tap_bits(5, 3, 0, 0);
      6:  return tap_bits(6, 5, 0, 0);
      7:  return tap_bits(7, 6, 0, 0);
      8:  return tap_bits(8, 6, 5, 4);
      9:  return tap_bits(9, 5, 0, 0);
      10: return tap_bits(10, 7, 0, 0);
      11: return tap_bits(11, 9, 0, 0);
      12: return tap_bits(12, 6, 4, 1);
      13: return tap_bits(13, 4, 3, 1);
      14: return tap_bits(14, 5, 3, 1);
      15: return tap_bits(15, 14, 0, 0);
      16: return tap_bits(16, 15, 13, 4);
      17: return tap_bits(17, 14, 0, 0);
      18: return tap_bits(18, 11, 0, 0);
      19: return tap_bits(19, 6, 2, 1);
      20: return tap_bits(20, 17, 0, 0);
      21: return tap_bits(21, 19, 0, 0);
      22: return tap_bits(22, 21, 0, 0);
      23: return tap_bits(23, 18, 0, 0);
      24: return tap_bits(24, 23, 22, 17);
      25: return tap_bits(25, 22, 0, 0);
      26: return tap_bits(26, 6, 2, 1);
      27: return tap_bits(27, 5, 2, 1);
      28: return tap_bits(28, 25, 0, 0);
      29: return tap_bits(29, 27, 0, 0);
      30: return tap_bits(30, 6, 4, 1);
      31: return tap_bits(31, 28, 0, 0);
      32: return tap_bits(32, 22, 2, 1);
      33: return tap_bits(33, 20, 0, 0);
      34: return tap_bits(34, 27, 2, 1);
      35: return tap_bits(35, 33, 0, 0);
      36: return tap_bits(36, 25, 0, 0);
      39: return tap_bits(39, 35, 0, 0);
      40: return tap_bits(40, 38, 21, 19);
      41: return tap_bits(41, 38, 0, 0);
      42: return tap_bits(42, 41, 20, 19);
      43: return tap_bits(43, 42, 38, 37);
      44: return tap_bits(44, 43, 18, 17);
      45: return tap_bits(45, 44, 42, 41);
      46: return tap_bits(46, 45, 26, 25);
      47: return tap_bits(47, 42, 0, 0);
      48: return tap_bits(48, 47, 21, 20);
      default: return tap_bits(w, w - 1, 0, 0);
    endcase
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lock_equiv_checker_if.sv
// Signal bundle between the checker, its controller and the two netlists under comparison.
interface lock_equiv_checker_if #(
  parameter int IN_W     = 41,
  parameter int OUT_W    = 32,
  parameter int KEY_W    = 16,
  parameter int PATTERNS = 10,
  parameter int NUM_KEYS = 10
) ();
  localparam int IDX_W = lock_chk_pkg::cnt_w(NUM_KEYS + 1);
  localparam int HD_W  = lock_chk_pkg::cnt_w(PATTERNS * OUT_W + 1);
  localparam int ERR_W = lock_chk_pkg::cnt_w(PATTERNS + 1);

  logic             start;
  logic [KEY_W-1:0] correct_key;
  logic [IN_W-1:0]  dut_in;
  logic [KEY_W-1:0] key_out;
  logic [OUT_W-1:0] ref_out;
  logic [OUT_W-1:0] obf_out;
  logic             busy;
  logic             done;
  logic             key_valid;
  logic [IDX_W-1:0] key_idx;
  logic [HD_W-1:0]  key_hd;
  logic [ERR_W-1:0] key_err;
  logic             pass;
  logic             leak;

  modport master (
    input  start, correct_key, ref_out, obf_out,
    output dut_in, key_out, busy, done, key_valid, key_idx, key_hd, key_err, pass, leak
  );

  modport slave (
    output start, correct_key, ref_out, obf_out,
    input  dut_in, key_out, busy, done, key_valid, key_idx, key_hd, key_err, pass, leak
  );
endinterface

// File: rtl/lfsr_gen.sv
// Maximal-length Fibonacci LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr_gen
  import lock_chk_pkg::*;
#(
  parameter int         W    = 16,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] value
);
  localparam logic [W-1:0]       SEED_NZ   = (SEED == '0) ? W'(1) : SEED;
  localparam logic [TAP_MAX-1:0] TAPS_FULL = lfsr_taps(W);
  localparam logic [W-1:0]       TAPS      = TAPS_FULL[W-1:0];

  logic [W-1:0] r_state;
  logic         w_fb;

  assign w_fb  = ^(r_state & TAPS);
  assign value = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_state <= SEED_NZ;
    else if (step) r_state <= {r_state[W-2:0], w_fb};
  end
endmodule

// File: rtl/lock_equiv_checker.sv
// Drives random patterns to an original and a key-locked netlist, once with the correct key
// and then with random wrong keys, and reports per-key Hamming distance and mismatch counts.
module lock_equiv_checker
  import lock_chk_pkg::*;
#(
  parameter int               IN_W     = 41,
  parameter int               OUT_W    = 32,
  parameter int               KEY_W    = 16,
  parameter int               PATTERNS = 10,
  parameter int               NUM_KEYS = 10,
  parameter int               SETTLE   = 1,
  parameter logic [IN_W-1:0]  SEED_IN  = 'h1,
  parameter logic [KEY_W-1:0] SEED_KEY = 'hACE1
) (
  input logic clk,
  input logic rst,
  lock_equiv_checker_if.master bus
);
  localparam int IDX_W = cnt_w(NUM_KEYS + 1);
  localparam int HD_W  = cnt_w(PATTERNS * OUT_W + 1);
  localparam int ERR_W = cnt_w(PATTERNS + 1);
  localparam int PAT_W = cnt_w(PATTERNS);
  localparam int SET_W = cnt_w(SETTLE);

  state_e           r_state, w_next;
  logic             w_in_step, w_key_step;
  logic [IN_W-1:0]  w_in_val;
  logic [KEY_W-1:0] w_key_val;

  logic [IN_W-1:0]  r_dut_in;
  logic [KEY_W-1:0] r_key_out, r_corr_key;
  logic [SET_W-1:0] r_settle_cnt;
  logic [PAT_W-1:0] r_pat_cnt;
  logic [IDX_W-1:0] r_key_idx;
  logic [HD_W-1:0]  r_hd_acc;
  logic [ERR_W-1:0] r_err_acc;
  logic             r_pass, r_leak;

  logic [OUT_W-1:0] w_diff;
  int unsigned      w_pop;
  logic             w_last_pat, w_last_key;

  lfsr_gen #(.W(IN_W), .SEED(SEED_IN)) u_lfsr_in (
    .clk(clk), .rst(rst), .step(w_in_step), .value(w_in_val)
  );

  lfsr_gen #(.W(KEY_W), .SEED(SEED_KEY)) u_lfsr_key (
    .clk(clk), .rst(rst), .step(w_key_step), .value(w_key_val)
  );

  assign w_diff     = bus.ref_out ^ bus.obf_out;
  assign w_pop      = popcount(POP_MAX'(w_diff));
  assign w_last_pat = (r_pat_cnt == PAT_W'(PATTERNS - 1));
  assign w_last_key = (r_key_idx == IDX_W'(NUM_KEYS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // WAIT lasts SETTLE cycles, giving the netlists a full settle window after dut_in changes.
  always_comb begin
    w_next     = r_state;
    w_in_step  = 1'b0;
    w_key_step = 1'b0;
    case (r_state)
      IDLE:   if (bus.start) w_next = DRIVE;
      DRIVE: begin
        w_next    = WAIT;
        w_in_step = 1'b1;
      end
      WAIT:   if (r_settle_cnt == SET_W'(SETTLE - 1)) w_next = SAMPLE;
      SAMPLE: w_next = w_last_pat ? REPORT : DRIVE;
      REPORT: begin
        if (w_last_key) begin
          w_next = DONE;
        end else begin
          w_next     = DRIVE;
          w_key_step = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dut_in     <= '0;
      r_key_out    <= '0;
      r_corr_key   <= '0;
      r_settle_cnt <= '0;
      r_pat_cnt    <= '0;
      r_key_idx    <= '0;
      r_hd_acc     <= '0;
      r_err_acc    <= '0;
      r_pass       <= 1'b0;
      r_leak       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_corr_key <= bus.correct_key;
            r_key_out  <= bus.correct_key;
            r_key_idx  <= '0;
            r_pat_cnt  <= '0;
            r_hd_acc   <= '0;
            r_err_acc  <= '0;
            r_pass     <= 1'b0;
            r_leak     <= 1'b0;
          end
        end
        DRIVE: begin
          r_dut_in     <= w_in_val;
          r_settle_cnt <= '0;
        end
        WAIT: r_settle_cnt <= r_settle_cnt + SET_W'(1);
        SAMPLE: begin
          r_hd_acc  <= r_hd_acc + HD_W'(w_pop);
          r_err_acc <= r_err_acc + ERR_W'(|w_diff);
          if (!w_last_pat) r_pat_cnt <= r_pat_cnt + PAT_W'(1);
        end
        REPORT: begin
          r_hd_acc  <= '0;
          r_err_acc <= '0;
          r_pat_cnt <= '0;
          // A random key that happens to equal the real key is not a leak.
          if (r_key_idx == '0)
            r_pass <= (r_err_acc == '0);
          else if ((r_err_acc == '0) && (r_key_out != r_corr_key))
            r_leak <= 1'b1;
          if (!w_last_key) begin
            r_key_idx <= r_key_idx + IDX_W'(1);
            r_key_out <= w_key_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in    = r_dut_in;
  assign bus.key_out   = r_key_out;
  assign bus.busy      = r_state inside {DRIVE, WAIT, SAMPLE, REPORT};
  assign bus.done      = (r_state == DONE);
  assign bus.key_valid = (r_state == REPORT);
  assign bus.key_idx   = r_key_idx;
  assign bus.key_hd    = r_hd_acc;
  assign bus.key_err   = r_err_acc;
  assign bus.pass      = r_pass;
  assign bus.leak      = r_leak;
endmodule
